// File: rtl/kmeans_centroid_recirc_pkg.sv
// Shared constants and types for the k-means centroid recirculation buffer.
package kmeans_centroid_recirc_pkg;

   localparam int CENT_DATA_BITS      = 512;
   localparam int CENT_WORDS_PER_LINE = 16;
   localparam int CENT_MAX_CLUSTERS   = 16;
   localparam int CENT_MAX_LINES      = 8;
   localparam int CENT_DEPTH          = CENT_MAX_CLUSTERS * CENT_MAX_LINES;
   localparam int CENT_ADDR_BITS      = $clog2(2 * CENT_DEPTH);
   localparam int NUM_CLUSTER_BITS    = $clog2(CENT_MAX_CLUSTERS);
   localparam int MAX_DEPTH_BITS      = $clog2(CENT_MAX_LINES * CENT_WORDS_PER_LINE);

   typedef enum logic [1:0] {RC_IDLE, RC_READ, RC_DRAIN} recirc_state_t;

   // Stream lines needed to carry one centroid of dim 32-bit words.
   function automatic int unsigned lines_per_centroid(input int unsigned dim);
      return (dim + CENT_WORDS_PER_LINE - 1) >> $clog2(CENT_WORDS_PER_LINE);
   endfunction

endpackage

// File: rtl/kmeans_cent_bram.sv
// Simple dual-port centroid RAM holding both ping-pong banks; the address MSB
// selects the bank. Read data is registered (one cycle latency).
module kmeans_cent_bram
   import kmeans_centroid_recirc_pkg::*;
#(
   parameter int DATA_BITS = CENT_DATA_BITS,
   parameter int ADDR_BITS = CENT_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
   logic [DATA_BITS-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/kmeans_centroid_recirc.sv
// Captures each updated-centroid frame into a ping-pong RAM and replays the last
// complete frame as the operator's AXI4-Stream centroid input.
module kmeans_centroid_recirc
   import kmeans_centroid_recirc_pkg::*;
#(
   parameter int DATA_BITS    = CENT_DATA_BITS,
   parameter int MAX_CLUSTERS = CENT_MAX_CLUSTERS,
   parameter int MAX_LINES    = CENT_MAX_LINES
) (
   input  logic                                           aclk,
   input  logic                                           areset,
   input  logic [$clog2(MAX_CLUSTERS):0]                  num_clusters,
   input  logic [$clog2(MAX_LINES*CENT_WORDS_PER_LINE):0] data_dim,
   input  logic [DATA_BITS-1:0]                           s_upd_tdata,
   input  logic                                           s_upd_tvalid,
   input  logic                                           s_upd_tlast,
   output logic [DATA_BITS-1:0]                           m_cent_tdata,
   output logic                                           m_cent_tvalid,
   output logic                                           m_cent_tlast,
   input  logic                                           m_cent_tready,
   input  logic                                           replay_start,
   output logic                                           replay_busy,
   output logic                                           bank_valid,
   output logic                                           capture_err
);

   localparam int DEPTH     = MAX_CLUSTERS * MAX_LINES;
   localparam int ADDR_BITS = $clog2(2 * DEPTH);
   localparam int LINE_BITS = ADDR_BITS - 1;
   localparam int CNT_BITS  = ADDR_BITS + 1;

   logic [CNT_BITS-1:0]  exp_lines;

   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic                 ovf_q, ovf_d;
   logic                 swap_pending_q, swap_pending_d;
   logic                 active_q, active_d;
   logic                 bank_valid_q, bank_valid_d;
   logic                 capture_err_q, capture_err_d;
   logic                 wr_full, wr_en, frame_ok, swap_fire;
   logic [ADDR_BITS-1:0] wr_addr;

   recirc_state_t        state_q, state_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 rd_en, rd_last, start_ok;

   logic [DATA_BITS-1:0] ram_rd_data;
   logic                 ram_vld_q, ram_vld_d;
   logic                 ram_last_q, ram_last_d;

   logic [DATA_BITS-1:0] fifo_data_q [2];
   logic [DATA_BITS-1:0] fifo_data_d [2];
   logic [1:0]           fifo_last_q, fifo_last_d;
   logic [1:0]           fifo_cnt_q, fifo_cnt_d;
   logic                 fifo_rd_q, fifo_rd_d;
   logic                 fifo_wr_q, fifo_wr_d;
   logic                 fifo_push, fifo_pop, pop, can_issue, head_last;
   logic [DATA_BITS-1:0] head_data;
   logic [2:0]           occ;

   always_comb begin
      exp_lines = CNT_BITS'(32'(num_clusters) * lines_per_centroid(32'(data_dim)));
   end

   // Capture path: runs regardless of the replay FSM and always writes the shadow bank.
   always_comb begin
      wr_full        = (wr_ptr_q == ADDR_BITS'(DEPTH));
      wr_en          = s_upd_tvalid && !wr_full;
      wr_addr        = {~active_q, wr_ptr_q[LINE_BITS-1:0]};
      frame_ok       = !ovf_q && !wr_full &&
                       (({1'b0, wr_ptr_q} + CNT_BITS'(1)) == exp_lines);
      swap_fire      = swap_pending_q && (state_q == RC_IDLE);

      wr_ptr_d       = wr_ptr_q;
      ovf_d          = ovf_q;
      swap_pending_d = swap_pending_q;
      active_d       = active_q;
      bank_valid_d   = bank_valid_q;
      capture_err_d  = capture_err_q;

      if (swap_fire) begin
         active_d       = ~active_q;
         bank_valid_d   = 1'b1;
         swap_pending_d = 1'b0;
      end

      if (s_upd_tvalid) begin
         if (wr_full) begin
            ovf_d         = 1'b1;
            capture_err_d = 1'b1;
         end
         if (s_upd_tlast) begin
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
            // A frame finishing in the swap cycle landed in the bank just published.
            if (frame_ok) begin
               swap_pending_d = !swap_fire;
            end else begin
               capture_err_d  = 1'b1;
               swap_pending_d = 1'b0;
            end
         end else if (!wr_full) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
         end
      end
   end

   // Output stage: RAM read register first in line only when the skid FIFO is empty.
   always_comb begin
      m_cent_tvalid = ram_vld_q || (fifo_cnt_q != 2'd0);
      head_data     = (fifo_cnt_q != 2'd0) ? fifo_data_q[fifo_rd_q] : ram_rd_data;
      head_last     = (fifo_cnt_q != 2'd0) ? fifo_last_q[fifo_rd_q] : ram_last_q;
      m_cent_tdata  = m_cent_tvalid ? head_data : '0;
      m_cent_tlast  = m_cent_tvalid && head_last;
      pop           = m_cent_tvalid && m_cent_tready;
      fifo_pop      = pop && (fifo_cnt_q != 2'd0);
      fifo_push     = ram_vld_q && !(pop && (fifo_cnt_q == 2'd0));
      // Beats still held after this edge; one more read must fit if nothing drains next cycle.
      occ           = 3'(fifo_cnt_q) + 3'(ram_vld_q) - 3'(pop);
      can_issue     = (occ < 3'd2);

      fifo_cnt_d    = fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
      fifo_wr_d     = fifo_wr_q ^ fifo_push;
      fifo_rd_d     = fifo_rd_q ^ fifo_pop;
      fifo_data_d   = fifo_data_q;
      fifo_last_d   = fifo_last_q;
      if (fifo_push) begin
         fifo_data_d[fifo_wr_q] = ram_rd_data;
         fifo_last_d[fifo_wr_q] = ram_last_q;
      end
   end

   // Replay FSM: next state.
   always_comb begin
      rd_last  = ({1'b0, rd_ptr_q} == (exp_lines - CNT_BITS'(1)));
      start_ok = replay_start && (bank_valid_q || swap_fire);
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      case (state_q)
         RC_IDLE: begin
            if (start_ok) begin
               state_d  = RC_READ;
               rd_ptr_d = '0;
            end
         end
         RC_READ: begin
            if (can_issue) begin
               rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
               if (rd_last) begin
                  state_d = RC_DRAIN;
               end
            end
         end
         RC_DRAIN: begin
            if (pop && m_cent_tlast) begin
               state_d = RC_IDLE;
            end
         end
         default: state_d = RC_IDLE;
      endcase
   end

   // Replay FSM: outputs. The active bank cannot change outside IDLE.
   always_comb begin
      replay_busy = (state_q != RC_IDLE);
      rd_en       = (state_q == RC_READ) && can_issue;
      rd_addr     = {active_q, rd_ptr_q[LINE_BITS-1:0]};
      ram_vld_d   = rd_en;
      ram_last_d  = rd_last;
      bank_valid  = bank_valid_q;
      capture_err = capture_err_q;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q        <= RC_IDLE;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         ovf_q          <= 1'b0;
         swap_pending_q <= 1'b0;
         active_q       <= 1'b0;
         bank_valid_q   <= 1'b0;
         capture_err_q  <= 1'b0;
         ram_vld_q      <= 1'b0;
         fifo_cnt_q     <= 2'd0;
         fifo_rd_q      <= 1'b0;
         fifo_wr_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         ovf_q          <= ovf_d;
         swap_pending_q <= swap_pending_d;
         active_q       <= active_d;
         bank_valid_q   <= bank_valid_d;
         capture_err_q  <= capture_err_d;
         ram_vld_q      <= ram_vld_d;
         fifo_cnt_q     <= fifo_cnt_d;
         fifo_rd_q      <= fifo_rd_d;
         fifo_wr_q      <= fifo_wr_d;
      end
   end

   always_ff @(posedge aclk) begin
      ram_last_q  <= ram_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
   end

   kmeans_cent_bram #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_bram (
      .clk     (aclk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (s_upd_tdata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

endmodule

// File: tb/tb_kmeans_centroid_recirc.sv
// Scoreboard bench for kmeans_centroid_recirc: directed capture/replay scenarios,
// expected beats queued at stimulus time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_kmeans_centroid_recirc;

   localparam int DW = 512;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          aclk;
   logic          areset;
   logic [4:0]    num_clusters;
   logic [7:0]    data_dim;
   logic [DW-1:0] s_upd_tdata;
   logic          s_upd_tvalid;
   logic          s_upd_tlast;
   logic [DW-1:0] m_cent_tdata;
   logic          m_cent_tvalid;
   logic          m_cent_tlast;
   logic          m_cent_tready;
   logic          replay_start;
   logic          replay_busy;
   logic          bank_valid;
   logic          capture_err;

   beat_t exp_q[$];
   int    checks;
   int    failures;
   int    hs_cnt;
   int    rdy_mode;

   kmeans_centroid_recirc dut (
      .aclk          (aclk),
      .areset        (areset),
      .num_clusters  (num_clusters),
      .data_dim      (data_dim),
      .s_upd_tdata   (s_upd_tdata),
      .s_upd_tvalid  (s_upd_tvalid),
      .s_upd_tlast   (s_upd_tlast),
      .m_cent_tdata  (m_cent_tdata),
      .m_cent_tvalid (m_cent_tvalid),
      .m_cent_tlast  (m_cent_tlast),
      .m_cent_tready (m_cent_tready),
      .replay_start  (replay_start),
      .replay_busy   (replay_busy),
      .bank_valid    (bank_valid),
      .capture_err   (capture_err)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // tready: 0 = always high, 1 = alternate every cycle, other = low.
   initial begin
      m_cent_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #2;
         case (rdy_mode)
            0:       m_cent_tready = 1'b1;
            1:       m_cent_tready = ~m_cent_tready;
            default: m_cent_tready = 1'b0;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mk_line(input logic [7:0] tag, input int i);
      logic [31:0] w;
      w = {tag, 24'(i)};
      return {16{w}};
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic send_frame(input logic [7:0] tag, input int n);
      for (int i = 0; i < n; i++) begin
         s_upd_tdata  = mk_line(tag, i);
         s_upd_tvalid = 1'b1;
         s_upd_tlast  = (i == n - 1);
         tick();
      end
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] tag, input int n, input int frame_len);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = mk_line(tag, i);
         b.last = (i == frame_len - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic pulse_start();
      replay_start = 1'b1;
      tick();
      replay_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         if (!replay_busy && exp_q.size() == 0) break;
         tick();
      end
      chk(name, {62'd0, replay_busy, exp_q.size() == 0}, 64'h1);
   endtask

   // Monitor: handshake scoreboard plus hold-while-stalled check.
   initial begin
      beat_t         e;
      logic          stall;
      logic [DW-1:0] sd;
      logic          sl;
      stall = 1'b0;
      sd    = '0;
      sl    = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               checks++;
               if (!m_cent_tvalid || m_cent_tdata !== sd || m_cent_tlast !== sl) begin
                  failures++;
                  $display("FAIL hold_stable actual vld=%0b w0=%h last=%0b required vld=1 w0=%h last=%0b",
                           m_cent_tvalid, m_cent_tdata[31:0], m_cent_tlast, sd[31:0], sl);
               end
            end
            if (m_cent_tvalid && m_cent_tready) begin
               hs_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_beat actual w0=%h last=%0b required none",
                           m_cent_tdata[31:0], m_cent_tlast);
               end else begin
                  e = exp_q.pop_front();
                  if (m_cent_tdata !== e.data || m_cent_tlast !== e.last) begin
                     failures++;
                     $display("FAIL beat actual w0=%h last=%0b required w0=%h last=%0b",
                              m_cent_tdata[31:0], m_cent_tlast, e.data[31:0], e.last);
                  end
               end
            end
            stall = m_cent_tvalid && !m_cent_tready;
            sd    = m_cent_tdata;
            sl    = m_cent_tlast;
         end
      end
   end

   initial begin
      int base;
      checks       = 0;
      failures     = 0;
      hs_cnt       = 0;
      rdy_mode     = 0;
      areset       = 1'b1;
      num_clusters = 5'd4;
      data_dim     = 8'd16;
      s_upd_tdata  = '0;
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
      replay_start = 1'b0;

      // 1: reset state, replay with no valid bank
      tick(); tick(); tick();
      chk("reset_outputs", {59'd0, m_cent_tvalid, m_cent_tlast, replay_busy, bank_valid, capture_err}, 64'h0);
      chk("reset_tdata", {63'd0, |m_cent_tdata}, 64'h0);
      areset = 1'b0;
      tick();
      pulse_start();
      repeat (4) tick();
      chk("t1_no_replay", {62'd0, m_cent_tvalid, replay_busy}, 64'h0);

      // 2: capture A, swap, replay latency and back-to-back beats
      send_frame(8'hA0, 4);
      chk("t2_bank_valid_before_swap", {63'd0, bank_valid}, 64'h0);
      tick();
      chk("t2_bank_valid_after_swap", {63'd0, bank_valid}, 64'h1);
      push_exp(8'hA0, 4, 4);
      pulse_start();
      chk("t2_tvalid_cycle1", {63'd0, m_cent_tvalid}, 64'h0);
      tick();
      chk("t2_tvalid_cycle2", {63'd0, m_cent_tvalid}, 64'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_back_to_back", {63'd0, m_cent_tvalid}, 64'h1);
      end
      wait_idle("t2_idle");
      chk("t2_tvalid_after", {63'd0, m_cent_tvalid}, 64'h0);

      // 3: alternating tready
      rdy_mode = 1;
      push_exp(8'hA0, 4, 4);
      pulse_start();
      wait_idle("t3_idle");
      rdy_mode = 0;
      tick();

      // 4: capture B while A replays; swap deferred to IDLE
      push_exp(8'hA0, 4, 4);
      pulse_start();
      send_frame(8'hB0, 4);
      chk("t4_busy_at_capture_end", {63'd0, replay_busy}, 64'h1);
      wait_idle("t4_idle_a");
      tick();
      chk("t4_bank_valid", {63'd0, bank_valid}, 64'h1);
      push_exp(8'hB0, 4, 4);
      pulse_start();
      wait_idle("t4_idle_b");

      // 5a: short frame -> error, no swap
      chk("t5_err_before", {63'd0, capture_err}, 64'h0);
      data_dim = 8'd20;
      send_frame(8'hC0, 7);
      chk("t5_err_short_frame", {63'd0, capture_err}, 64'h1);
      tick(); tick();
      data_dim = 8'd16;
      push_exp(8'hB0, 4, 4);
      pulse_start();
      wait_idle("t5_idle_prev_bank");
      chk("t5_bank_still_valid", {63'd0, bank_valid}, 64'h1);

      // 5b: overflow with DEPTH+2 beats
      areset = 1'b1;
      tick();
      areset = 1'b0;
      tick();
      chk("t5_reset_clears", {62'd0, capture_err, bank_valid}, 64'h0);
      num_clusters = 5'd16;
      data_dim     = 8'd128;
      for (int i = 0; i < 130; i++) begin
         s_upd_tdata  = mk_line(8'hE0, i);
         s_upd_tvalid = 1'b1;
         s_upd_tlast  = (i == 129);
         tick();
         if (i == 127) chk("t5_err_at_depth", {63'd0, capture_err}, 64'h0);
         if (i == 128) chk("t5_err_overflow", {63'd0, capture_err}, 64'h1);
      end
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
      tick();
      chk("t5_overflow_final", {62'd0, capture_err, bank_valid}, 64'h2);

      // 6: reset after the second handshake aborts the replay
      num_clusters = 5'd4;
      data_dim     = 8'd16;
      send_frame(8'hD0, 4);
      tick();
      chk("t6_bank_valid", {63'd0, bank_valid}, 64'h1);
      push_exp(8'hD0, 2, 4);
      base = hs_cnt;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         if (hs_cnt - base >= 2) break;
         tick();
      end
      chk("t6_two_handshakes", 64'(hs_cnt - base), 64'd2);
      areset   = 1'b1;
      rdy_mode = 2;
      tick();
      areset = 1'b0;
      chk("t6_abort", {61'd0, m_cent_tvalid, bank_valid, replay_busy}, 64'h0);
      chk("t6_beats_consumed", 64'(exp_q.size()), 64'd0);
      rdy_mode = 0;
      pulse_start();
      repeat (6) tick();
      chk("t6_no_more_beats", {62'd0, m_cent_tvalid, replay_busy}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
